// File: rtl/byte_bus_seq.sv
// byte_bus_seq: carries 16-bit CPU transfers over an 8-bit memory bus,
// splitting writes into two byte cycles and gathering read bytes into a word.
module byte_bus_seq #(
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_stb,
  input  logic          cpu_we,
  input  logic          cpu_byte,
  input  logic [AW-1:0] cpu_adr,
  input  logic [15:0]   cpu_dat_i,
  output logic [15:0]   cpu_dat_o,
  output logic          cpu_ack,
  output logic          mem_stb,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [7:0]    mem_dat_o,
  input  logic [7:0]    mem_dat_i,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic          we_q, we_d;
  logic          byte_q, byte_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [7:0]    dhi_q, dhi_d;
  logic [15:0]   rdat_q, rdat_d;
  logic          ack_q, ack_d;
  logic          mstb_q, mstb_d;
  logic          mwe_q, mwe_d;
  logic [AW-1:0] madr_q, madr_d;
  logic [7:0]    mdat_q, mdat_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      adr_q   <= '0;
      dhi_q   <= 8'h00;
      rdat_q  <= 16'h0000;
      ack_q   <= 1'b0;
      mstb_q  <= 1'b0;
      mwe_q   <= 1'b0;
      madr_q  <= '0;
      mdat_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      adr_q   <= adr_d;
      dhi_q   <= dhi_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      mstb_q  <= mstb_d;
      mwe_q   <= mwe_d;
      madr_q  <= madr_d;
      mdat_q  <= mdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    byte_d  = byte_q;
    adr_d   = adr_q;
    dhi_d   = dhi_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    mstb_d  = mstb_q;
    mwe_d   = mwe_q;
    madr_d  = madr_q;
    mdat_d  = mdat_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_stb) begin
          we_d    = cpu_we;
          byte_d  = cpu_byte;
          adr_d   = cpu_adr;
          dhi_d   = cpu_dat_i[15:8];
          state_d = LO;
          mstb_d  = 1'b1;
          mwe_d   = cpu_we;
          madr_d  = cpu_adr;
          mdat_d  = cpu_dat_i[7:0];
        end
      end
      LO: begin
        if (mem_ack) begin
          if (!we_q) begin
            rdat_d[7:0] = mem_dat_i;
            if (byte_q) rdat_d[15:8] = 8'h00;
          end
          if (byte_q) begin
            state_d = DONE;
            mstb_d  = 1'b0;
          end else begin
            // strobe stays up: second byte follows with no idle cycle
            state_d = HI;
            madr_d  = adr_q + AW'(1);
            mdat_d  = dhi_q;
          end
        end
      end
      HI: begin
        if (mem_ack) begin
          if (!we_q) rdat_d[15:8] = mem_dat_i;
          state_d = DONE;
          mstb_d  = 1'b0;
        end
      end
      DONE: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_dat_o = rdat_q;
  assign cpu_ack   = ack_q;
  assign mem_stb   = mstb_q;
  assign mem_we    = mwe_q;
  assign mem_adr   = madr_q;
  assign mem_dat_o = mdat_q;

endmodule

// File: tb/tb_byte_bus_seq.sv
// tb_byte_bus_seq: drives byte_bus_seq against a behavioural byte memory
// and a transaction-level reference of word split/gather rules.
module tb_byte_bus_seq;

  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_stb = 1'b0;
  logic          cpu_we = 1'b0;
  logic          cpu_byte = 1'b0;
  logic [AW-1:0] cpu_adr = '0;
  logic [15:0]   cpu_dat_i = 16'h0;
  logic [15:0]   cpu_dat_o;
  logic          cpu_ack;
  logic          mem_stb;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [7:0]    mem_dat_o;
  logic [7:0]    mem_dat_i = 8'h00;
  logic          mem_ack;

  logic resp_ack = 1'b0;
  logic stray_ack = 1'b0;
  int   wait_n = 0;
  int   cnt = 0;

  int vec = 0;
  int errs = 0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [7:0]    dat;
  } bc_t;

  bc_t         log_q[$];
  logic [7:0]  mem_arr [logic [AW-1:0]];

  assign mem_ack = resp_ack | stray_ack;

  always #5 clk = ~clk;

  byte_bus_seq #(.AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_stb   (cpu_stb),
    .cpu_we    (cpu_we),
    .cpu_byte  (cpu_byte),
    .cpu_adr   (cpu_adr),
    .cpu_dat_i (cpu_dat_i),
    .cpu_dat_o (cpu_dat_o),
    .cpu_ack   (cpu_ack),
    .mem_stb   (mem_stb),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_dat_o (mem_dat_o),
    .mem_dat_i (mem_dat_i),
    .mem_ack   (mem_ack)
  );

  // Byte memory: acks after wait_n idle cycles, logs every byte cycle
  always @(posedge clk) begin
    #1;
    if (resp_ack) begin
      resp_ack = 1'b0;
      cnt = 0;
    end
    if (mem_stb) begin
      if (cnt >= wait_n) begin
        if (mem_we) begin
          mem_arr[mem_adr] = mem_dat_o;
          log_q.push_back({1'b1, mem_adr, mem_dat_o});
        end else begin
          if (!mem_arr.exists(mem_adr)) mem_arr[mem_adr] = 8'($urandom);
          mem_dat_i = mem_arr[mem_adr];
          log_q.push_back({1'b0, mem_adr, mem_arr[mem_adr]});
        end
        resp_ack = 1'b1;
        cnt = 0;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic run_txn(input logic we, input logic bt,
                         input logic [AW-1:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output int lat,
                         output logic ack2);
    @(negedge clk);
    cpu_stb = 1'b1;
    cpu_we = we;
    cpu_byte = bt;
    cpu_adr = a;
    cpu_dat_i = d;
    @(posedge clk);
    #1;
    cpu_stb = 1'b0;
    cpu_we = 1'($urandom);
    cpu_byte = 1'($urandom);
    cpu_adr = AW'($urandom);
    cpu_dat_i = 16'($urandom);
    lat = 1;
    while (cpu_ack !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = cpu_dat_o;
    @(posedge clk);
    #1;
    ack2 = cpu_ack;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    vec++;
    if ({cpu_ack, mem_stb, mem_we} !== 3'b000) begin
      errs++;
      $display("FAIL reset_ctl got %b want 000", {cpu_ack, mem_stb, mem_we});
    end
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (cpu_dat_o !== 16'h0000) begin
      errs++;
      $display("FAIL reset_cpu_dat got %h want 0000", cpu_dat_o);
    end
    vec++;
    if (mem_adr !== '0 || mem_dat_o !== 8'h00) begin
      errs++;
      $display("FAIL reset_mem got adr %h dat %h want 0", mem_adr, mem_dat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_write;
    logic [15:0] rd;
    int lat;
    logic a2;
    wait_n = 0;
    log_q.delete();
    run_txn(1'b1, 1'b0, 20'h00100, 16'hBEEF, rd, lat, a2);
    vec++;
    if (log_q.size() != 2) begin
      errs++;
      $display("FAIL ww_cycles got %0d want 2", log_q.size());
    end else begin
      vec++;
      if (log_q[0] !== {1'b1, 20'h00100, 8'hEF}) begin
        errs++;
        $display("FAIL ww_lo got %h want %h", log_q[0], {1'b1, 20'h00100, 8'hEF});
      end
      vec++;
      if (log_q[1] !== {1'b1, 20'h00101, 8'hBE}) begin
        errs++;
        $display("FAIL ww_hi got %h want %h", log_q[1], {1'b1, 20'h00101, 8'hBE});
      end
    end
    vec++;
    if (lat != 4) begin
      errs++;
      $display("FAIL ww_latency got %0d want 4", lat);
    end
    vec++;
    if (a2 !== 1'b0) begin
      errs++;
      $display("FAIL ww_ack_pulse got %b want 0", a2);
    end
  endtask

  task automatic test_word_read_odd;
    logic [15:0] rd;
    int lat;
    logic a2;
    wait_n = 2;
    mem_arr[20'h00FFF] = 8'h34;
    mem_arr[20'h01000] = 8'h12;
    log_q.delete();
    run_txn(1'b0, 1'b0, 20'h00FFF, 16'h0000, rd, lat, a2);
    vec++;
    if (rd !== 16'h1234) begin
      errs++;
      $display("FAIL wr_data got %h want 1234", rd);
    end
    vec++;
    if (log_q.size() != 2 || log_q[0].adr !== 20'h00FFF ||
        log_q[1].adr !== 20'h01000) begin
      errs++;
      $display("FAIL wr_adrs got n=%0d want 00FFF,01000", log_q.size());
    end
    vec++;
    if (lat != 8) begin
      errs++;
      $display("FAIL wr_latency got %0d want 8", lat);
    end
    vec++;
    if (a2 !== 1'b0) begin
      errs++;
      $display("FAIL wr_ack_pulse got %b want 0", a2);
    end
  endtask

  task automatic test_byte_read;
    logic [15:0] rd;
    int lat;
    logic a2;
    wait_n = 0;
    mem_arr[20'h00010] = 8'hA5;
    log_q.delete();
    run_txn(1'b0, 1'b1, 20'h00010, 16'hFFFF, rd, lat, a2);
    vec++;
    if (rd !== 16'h00A5) begin
      errs++;
      $display("FAIL br_data got %h want 00A5", rd);
    end
    vec++;
    if (log_q.size() != 1) begin
      errs++;
      $display("FAIL br_cycles got %0d want 1", log_q.size());
    end
    vec++;
    if (lat != 3) begin
      errs++;
      $display("FAIL br_latency got %0d want 3", lat);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] rd;
    int lat;
    logic a2;
    wait_n = 0;
    log_q.delete();
    run_txn(1'b1, 1'b0, 20'hFFFFF, 16'h5A3C, rd, lat, a2);
    vec++;
    if (log_q.size() != 2 || log_q[0] !== {1'b1, 20'hFFFFF, 8'h3C} ||
        log_q[1] !== {1'b1, 20'h00000, 8'h5A}) begin
      errs++;
      $display("FAIL wrap got n=%0d want 3C@FFFFF 5A@00000", log_q.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd;
    int lat;
    int n;
    logic a2;
    wait_n = 3;
    @(negedge clk);
    cpu_stb = 1'b1;
    cpu_we = 1'b1;
    cpu_byte = 1'b0;
    cpu_adr = 20'h20000;
    cpu_dat_i = 16'hC0DE;
    @(posedge clk);
    #1;
    cpu_stb = 1'b0;
    n = 0;
    while (mem_adr !== 20'h20001 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    vec++;
    if (mem_adr !== 20'h20001 || mem_stb !== 1'b1) begin
      errs++;
      $display("FAIL rm_reach_hi got adr %h stb %b", mem_adr, mem_stb);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if ({mem_stb, cpu_ack, mem_adr, mem_dat_o} !== '0) begin
      errs++;
      $display("FAIL rm_async got stb %b ack %b adr %h dat %h want 0",
               mem_stb, cpu_ack, mem_adr, mem_dat_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n = 0;
    log_q.delete();
    run_txn(1'b1, 1'b1, 20'h30007, 16'h0077, rd, lat, a2);
    vec++;
    if (log_q.size() != 1 || log_q[0] !== {1'b1, 20'h30007, 8'h77} || lat != 3) begin
      errs++;
      $display("FAIL rm_fresh got n=%0d lat %0d want 77@30007 lat 3",
               log_q.size(), lat);
    end
  endtask

  task automatic test_stray;
    logic [15:0] rd;
    int lat;
    logic a2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stray_ack = 1'b1;
      @(posedge clk);
      #1;
      stray_ack = 1'b0;
      vec++;
      if (mem_stb !== 1'b0 || cpu_ack !== 1'b0) begin
        errs++;
        $display("FAIL stray_%0d got stb %b ack %b want 0 0", i, mem_stb, cpu_ack);
      end
    end
    wait_n = 1;
    mem_arr[20'h44444] = 8'h5C;
    run_txn(1'b0, 1'b1, 20'h44444, 16'h0, rd, lat, a2);
    vec++;
    if (rd !== 16'h005C || lat != 4) begin
      errs++;
      $display("FAIL stray_after got %h lat %0d want 005C lat 4", rd, lat);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    wait_n = 0;
    mem_arr[20'h0ABCD] = 8'h9E;
    log_q.delete();
    @(negedge clk);
    cpu_stb = 1'b1;
    cpu_we = 1'b1;
    cpu_byte = 1'b1;
    cpu_adr = 20'h05555;
    cpu_dat_i = 16'h0011;
    @(posedge clk);
    #1;
    n = 0;
    while (cpu_ack !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    cpu_we = 1'b0;
    cpu_adr = 20'h0ABCD;
    @(posedge clk);
    #1;
    cpu_stb = 1'b0;
    vec++;
    if (mem_stb !== 1'b1 || mem_adr !== 20'h0ABCD || mem_we !== 1'b0) begin
      errs++;
      $display("FAIL b2b_start got stb %b adr %h we %b want 1 0ABCD 0",
               mem_stb, mem_adr, mem_we);
    end
    n = 0;
    while (cpu_ack !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    vec++;
    if (cpu_dat_o !== 16'h009E || log_q.size() != 2 ||
        log_q[0] !== {1'b1, 20'h05555, 8'h11}) begin
      errs++;
      $display("FAIL b2b_result got %h n=%0d want 009E n=2", cpu_dat_o, log_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [15:0] rd, model_rd, d;
    logic [AW-1:0] a, a1;
    logic we, bt, a2;
    int lat, exp_lat, nb;
    bc_t exp_q[$];
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_rd = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom);
      bt = 1'($urandom);
      a = (i % 8 == 7) ? 20'hFFFFF : AW'($urandom);
      a1 = a + 20'd1;
      d = 16'($urandom);
      wait_n = $urandom_range(0, 2);
      nb = bt ? 1 : 2;
      exp_q.delete();
      if (we) begin
        exp_q.push_back({1'b1, a, d[7:0]});
        if (!bt) exp_q.push_back({1'b1, a1, d[15:8]});
      end else begin
        if (!mem_arr.exists(a)) mem_arr[a] = 8'($urandom);
        if (!mem_arr.exists(a1)) mem_arr[a1] = 8'($urandom);
        exp_q.push_back({1'b0, a, mem_arr[a]});
        if (!bt) exp_q.push_back({1'b0, a1, mem_arr[a1]});
        model_rd = bt ? {8'h00, mem_arr[a]} : {mem_arr[a1], mem_arr[a]};
      end
      exp_lat = (bt ? 3 : 4) + wait_n * nb;
      log_q.delete();
      run_txn(we, bt, a, d, rd, lat, a2);
      vec++;
      if (log_q.size() != nb) begin
        errs++;
        $display("FAIL rnd%0d_cycles got %0d want %0d", i, log_q.size(), nb);
      end else begin
        for (int k = 0; k < nb; k++) begin
          vec++;
          if (log_q[k] !== exp_q[k]) begin
            errs++;
            $display("FAIL rnd%0d_byte%0d got %h want %h", i, k, log_q[k], exp_q[k]);
          end
        end
      end
      vec++;
      if (rd !== model_rd) begin
        errs++;
        $display("FAIL rnd%0d_data got %h want %h", i, rd, model_rd);
      end
      vec++;
      if (lat != exp_lat || a2 !== 1'b0) begin
        errs++;
        $display("FAIL rnd%0d_timing got lat %0d ack2 %b want %0d 0",
                 i, lat, a2, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_word_read_odd();
    test_byte_read();
    test_wrap();
    test_reset_mid();
    test_stray();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/byte_bus_seq.md
Name: byte_bus_seq

Overview:
- Sequencer that carries 16-bit processor data transfers over an 8-bit memory bus.
- Writes: splits each word into two byte cycles. Reads: collects two bytes into one word.
- This is the opposite direction of the byte-select mux: it spreads a word out to bytes and gathers bytes back into a word.
- Sits between the core's 16-bit bus port and the 8-bit external memory controller.

Parameters:
- AW, 20, address width on both sides (8086 physical address).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_stb  input  1  transaction request, sampled only in IDLE.
- cpu_we  input  1  1 = write, 0 = read; sampled with cpu_stb.
- cpu_byte  input  1  1 = single-byte access, 0 = word access.
- cpu_adr  input  AW  byte address of the low byte.
- cpu_dat_i  input  16  write data; [7:0] at cpu_adr, [15:8] at cpu_adr+1.
- cpu_dat_o  output  16  read data, valid while cpu_ack = 1.
- cpu_ack  output  1  one-cycle completion pulse.
- mem_stb  output  1  byte-cycle request.
- mem_we  output  1  byte-cycle direction.
- mem_adr  output  AW  byte-cycle address.
- mem_dat_o  output  8  byte write data.
- mem_dat_i  input  8  byte read data, valid with mem_ack.
- mem_ack  input  1  byte-cycle completion, one or more cycles after mem_stb rises.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State = IDLE.
  - cpu_ack = 0, cpu_dat_o = 16'h0000.
  - mem_stb = 0, mem_we = 0, mem_adr = 0, mem_dat_o = 8'h00.
- All outputs are registered.
- Latching in IDLE: when cpu_stb = 1, latch cpu_we, cpu_byte, cpu_adr and cpu_dat_i. Later changes on the cpu_* inputs are ignored until the next IDLE.
- State machine (IDLE, LO, HI, DONE):
  - IDLE -> LO on cpu_stb. On that same edge: mem_stb = 1, mem_adr = latched adr, mem_we = latched we, mem_dat_o = dat[7:0].
  - LO, mem_ack = 0: hold. mem_stb and all mem_* outputs stay stable.
  - LO, mem_ack = 1, read: capture mem_dat_i into cpu_dat_o[7:0]. For a byte read, also clear cpu_dat_o[15:8] to 0 (zero-extend).
  - LO, mem_ack = 1, byte access: -> DONE, mem_stb = 0.
  - LO, mem_ack = 1, word access: -> HI. mem_stb stays 1 with no idle cycle. mem_adr = adr + 1 mod 2^AW (AW'hFFFFF + 1 wraps to 0). mem_dat_o = dat[15:8].
  - HI, mem_ack = 1: for a read, capture mem_dat_i into cpu_dat_o[15:8]. -> DONE, mem_stb = 0.
  - DONE: cpu_ack = 1 for exactly one cycle, then -> IDLE. cpu_dat_o holds its value until the next read capture.
- Handshake rules:
  - mem_ack seen in IDLE or DONE is ignored.
  - mem_ack is evaluated only while mem_stb = 1.
  - The master must drop cpu_stb on the cycle after cpu_ack. If cpu_stb is still high in IDLE, a new transaction starts.
- Latency with zero-wait memory (mem_ack on the first cycle mem_stb is high):
  - Byte access: cpu_ack 3 cycles after cpu_stb is sampled.
  - Word access: cpu_ack 4 cycles after cpu_stb is sampled.
  - Each memory wait cycle adds one cycle.
- Reset mid-operation: returns to IDLE immediately with all outputs at reset values. A partially written word is not rolled back.
- Alignment: no alignment restriction. Odd addresses are handled the same way as even ones.

Test Plan:
- Word write: adr = 20'h00100, dat = 16'hBEEF, zero-wait mem -> mem sees 8'hEF @ 00100 then 8'hBE @ 00101, back-to-back; cpu_ack 4 cycles after request.
- Word read, odd address: adr = 20'h00FFF, mem returns 8'h34 then 8'h12, each with 2 wait cycles -> mem_adr 00FFF then 01000; cpu_dat_o = 16'h1234 with cpu_ack; one ack pulse only.
- Byte read: adr = 20'h00010, mem returns 8'hA5 -> exactly one mem_stb cycle; cpu_dat_o = 16'h00A5; ack 3 cycles after request.
- Address wrap: word write at AW'hFFFFF, dat = 16'h5A3C -> 8'h3C @ FFFFF, then 8'h5A @ 00000.
- Reset mid-word: rst_n low while in HI -> mem_stb, cpu_ack low immediately (asynchronous); a stb after release starts a fresh LO cycle at the new address.
- Stray/held inputs: mem_ack pulses in IDLE produce no state change; cpu_stb held high through cpu_ack triggers a second transaction starting in the cycle after the return to IDLE.
